spi_adc_scanner: RTL and testbench

Parametrised SPI master for the MCP3202/3204/3208 family of 12-bit ADCs, successor to the fixed single-channel MCP3202 front end. Scans a runtime-selectable set of channels round-robin, one conversion per sample slot, with per-channel single-ended/differential selection. Results go out on a valid/ready stream tagged with channel number, with overrun signalling. Sits between the ADC pins and the audio mixer/sample FIFO.

---
 rtl/spi_adc_pkg.sv | 37 +++
 rtl/spi_sck_gen.sv | 41 ++++
 rtl/spi_adc_scanner.sv | 192 +++++++++++++++++++
 tb/tb_spi_adc_scanner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared types and command-format helpers for the MCP320x SPI ADC scanner.
package spi_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_CS,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int unsigned CMD_LEN_MCP3202 = 4;
  localparam int unsigned CMD_LEN_MCP3208 = 6;
  localparam int unsigned CMD_MAX         = 6;

  function automatic int unsigned cmd_len(input int unsigned channels);
    return (channels == 2) ? CMD_LEN_MCP3202 : CMD_LEN_MCP3208;
  endfunction

  function automatic int unsigned frame_bits(input int unsigned channels,
                                             input int unsigned data_width);
    return cmd_len(channels) + 1 + data_width;
  endfunction

  // Command word right-aligned in CMD_MAX bits, START bit first on the wire.
  function automatic logic [CMD_MAX-1:0] build_cmd(input int unsigned channels,
                                                   input logic [2:0]  ch,
                                                   input logic        diff);
    logic [CMD_MAX-1:0] cmd;
    if (channels == 2) begin
      cmd = {2'b00, 1'b1, ~diff, ch[0], 1'b1};
    end else begin
      cmd = {1'b1, ~diff, (channels == 4) ? 1'b0 : ch[2], ch[1], ch[0], 1'b0};
    end
    return cmd;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: low half-period first, registered sck plus edge strobes
// that are high on the clk edge where sck is about to rise or fall.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 150
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic sck_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned PH_W = $clog2(CLK_DIV);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            sck_d;

  always_comb begin
    phase_d = '0;
    if (en_i && (phase_q != PH_W'(CLK_DIV - 1))) begin
      phase_d = phase_q + PH_W'(1);
    end
    sck_d = en_i && (phase_d >= PH_W'(HALF));
  end

  assign rise_c_o = en_i && (phase_q == PH_W'(HALF - 1));
  assign fall_c_o = en_i && (phase_q == PH_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      sck_o   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sck_o   <= sck_d;
    end
  end

endmodule

// File: rtl/spi_adc_scanner.sv
// Round-robin MCP3202/3204/3208 scanner: one conversion per sample slot,
// results on a valid/ready stream tagged with channel, with overrun pulse.
module spi_adc_scanner
  import spi_adc_pkg::*;
#(
  parameter  int unsigned CHANNELS      = 2,
  parameter  int unsigned DATA_WIDTH    = 12,
  parameter  int unsigned CLK_DIV       = 150,
  parameter  int unsigned SAMPLE_PERIOD = 3062,
  parameter  int unsigned CS_HIGH_MIN   = 68,
  localparam int unsigned CH_W          = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [CHANNELS-1:0]   ch_mask,
  input  logic [CHANNELS-1:0]   diff_mask,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sck,
  output logic                  cs_n,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CH_W-1:0]       o_channel,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  overrun
);

  localparam int unsigned CMD_LEN    = cmd_len(CHANNELS);
  localparam int unsigned FRAME_BITS = frame_bits(CHANNELS, DATA_WIDTH);
  localparam int unsigned CNT_W      = $clog2(SAMPLE_PERIOD);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  if (!(CHANNELS == 2 || CHANNELS == 4 || CHANNELS == 8) || (CLK_DIV % 2) != 0 ||
      CLK_DIV < 4 || CS_HIGH_MIN < 2 || DATA_WIDTH < 2 ||
      (CS_HIGH_MIN + FRAME_BITS * CLK_DIV + 2) >= SAMPLE_PERIOD) begin : g_param_check
    $error("spi_adc_scanner: illegal parameter combination");
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CMD_LEN-1:0]    cmd_q, cmd_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  done_q, done_d;
  logic                  cs_n_d, mosi_d, o_valid_d, overrun_d;
  logic [DATA_WIDTH-1:0] o_data_d;
  logic [CH_W-1:0]       o_channel_d;

  logic                  sck_run_c, sck_rise_c, sck_fall_c;
  logic [CH_W-1:0]       ch_nxt_c, ch_idx_c;
  logic                  ch_any_c;

  assign sck_run_c = (state_q == ST_SHIFT) && en;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (sck_run_c),
    .sck_o    (sck),
    .rise_c_o (sck_rise_c),
    .fall_c_o (sck_fall_c)
  );

  // Lowest set mask bit above the previous channel, wrapping back to it last.
  always_comb begin
    ch_nxt_c = ch_q;
    ch_idx_c = '0;
    ch_any_c = 1'b0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      ch_idx_c = ch_q + CH_W'(i);
      if (!ch_any_c && ch_mask[ch_idx_c]) begin
        ch_any_c = 1'b1;
        ch_nxt_c = ch_idx_c;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    ch_d        = ch_q;
    cmd_d       = cmd_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    cs_n_d      = cs_n;
    mosi_d      = mosi;
    o_data_d    = o_data;
    o_channel_d = o_channel;
    o_valid_d   = o_valid;
    overrun_d   = 1'b0;

    if (en && (cnt_q != CNT_W'(SAMPLE_PERIOD - 1))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (!en) begin
      // Abort: partial frame dropped, next scan restarts from the lowest channel.
      state_d = ST_IDLE;
      cs_n_d  = 1'b1;
      mosi_d  = 1'b0;
      bit_d   = '0;
      ch_d    = CH_W'(CHANNELS - 1);
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cnt_q == '0) begin
            if (ch_any_c) begin
              state_d = ST_WAIT_CS;
              ch_d    = ch_nxt_c;
              cmd_d   = CMD_LEN'(build_cmd(CHANNELS, 3'(ch_nxt_c), diff_mask[ch_nxt_c]));
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_WAIT_CS: begin
          if (cnt_q == CNT_W'(CS_HIGH_MIN - 1)) begin
            state_d = ST_SHIFT;
            cs_n_d  = 1'b0;
            mosi_d  = cmd_q[CMD_LEN-1];
            cmd_d   = cmd_q << 1;
            bit_d   = '0;
          end
        end
        ST_SHIFT: begin
          if (sck_rise_c && (bit_q > BIT_W'(CMD_LEN))) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], miso};
          end
          if (sck_fall_c) begin
            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
              state_d = ST_DONE;
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              bit_d  = bit_q + BIT_W'(1);
              mosi_d = cmd_q[CMD_LEN-1];
              cmd_d  = cmd_q << 1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Result register loads one cycle after frame end; a same-cycle accept is not an overrun.
    if (done_q) begin
      o_data_d    = shift_q;
      o_channel_d = ch_q;
      o_valid_d   = 1'b1;
      overrun_d   = o_valid && !o_ready;
    end else if (o_valid && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ch_q      <= CH_W'(CHANNELS - 1);
      cmd_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      o_data    <= '0;
      o_channel <= '0;
      o_valid   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      cmd_q     <= cmd_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      cs_n      <= cs_n_d;
      mosi      <= mosi_d;
      o_data    <= o_data_d;
      o_channel <= o_channel_d;
      o_valid   <= o_valid_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench: default 2-channel scanner plus a fast 8-channel instance,
// each driven by a small MCP320x pin model.
module tb_spi_adc_scanner;

  localparam int SP_A = 3062;
  localparam int SP_B = 100;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // 2-channel instance, default parameters
  logic        en_a, miso_a, mosi_a, sck_a, cs_n_a, o_valid_a, o_ready_a, overrun_a;
  logic [1:0]  ch_mask_a, diff_mask_a;
  logic [11:0] o_data_a;
  logic [0:0]  o_channel_a;

  // 8-channel instance, short timing
  logic        en_b, miso_b, mosi_b, sck_b, cs_n_b, o_valid_b, o_ready_b, overrun_b;
  logic [7:0]  ch_mask_b, diff_mask_b;
  logic [11:0] o_data_b;
  logic [2:0]  o_channel_b;

  spi_adc_scanner dut_a (
    .clk(clk), .reset_n(reset_n), .en(en_a), .ch_mask(ch_mask_a), .diff_mask(diff_mask_a),
    .miso(miso_a), .mosi(mosi_a), .sck(sck_a), .cs_n(cs_n_a), .o_data(o_data_a),
    .o_channel(o_channel_a), .o_valid(o_valid_a), .o_ready(o_ready_a), .overrun(overrun_a)
  );

  spi_adc_scanner #(.CHANNELS(8), .DATA_WIDTH(12), .CLK_DIV(4), .SAMPLE_PERIOD(SP_B),
                    .CS_HIGH_MIN(6)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en_b), .ch_mask(ch_mask_b), .diff_mask(diff_mask_b),
    .miso(miso_b), .mosi(mosi_b), .sck(sck_b), .cs_n(cs_n_b), .o_data(o_data_b),
    .o_channel(o_channel_b), .o_valid(o_valid_b), .o_ready(o_ready_b), .overrun(overrun_b)
  );

  int errors = 0;
  int checks = 0;
  int pos    = 0;

  // ADC pin model A: 4 command bits, null bit, 12 data bits
  logic [11:0] adc_a = '0;
  logic [5:0]  cmd_cap_a = '0;
  logic        cs_p_a = 1'b1, sck_p_a = 1'b0, tail_bad_a = 1'b0;
  int          rcnt_a = 0, last_rcnt_a = 0, cs_low_a = 0;

  always @(negedge clk) begin
    if (cs_n_a && !cs_p_a) last_rcnt_a = rcnt_a;
    if (!cs_n_a && cs_p_a) cmd_cap_a = '0;
    if (cs_n_a) begin
      rcnt_a = 0;
      miso_a = 1'b0;
    end else begin
      cs_low_a = cs_low_a + 1;
      if (sck_a && !sck_p_a) begin
        if (rcnt_a < 4) cmd_cap_a[3 - rcnt_a] = mosi_a;
        else if (mosi_a) tail_bad_a = 1'b1;
        rcnt_a = rcnt_a + 1;
      end else if (!sck_a && sck_p_a) begin
        miso_a = (rcnt_a >= 5 && rcnt_a <= 16) ? adc_a[16 - rcnt_a] : 1'b0;
      end
    end
    cs_p_a  = cs_n_a;
    sck_p_a = sck_a;
  end

  // ADC pin model B: 6 command bits, null bit, 12 data bits
  logic [11:0] adc_b = '0;
  logic [5:0]  cmd_cap_b = '0;
  logic        cs_p_b = 1'b1, sck_p_b = 1'b0, tail_bad_b = 1'b0;
  int          rcnt_b = 0, last_rcnt_b = 0;

  always @(negedge clk) begin
    if (cs_n_b && !cs_p_b) last_rcnt_b = rcnt_b;
    if (!cs_n_b && cs_p_b) cmd_cap_b = '0;
    if (cs_n_b) begin
      rcnt_b = 0;
      miso_b = 1'b0;
    end else begin
      if (sck_b && !sck_p_b) begin
        if (rcnt_b < 6) cmd_cap_b[5 - rcnt_b] = mosi_b;
        else if (mosi_b) tail_bad_b = 1'b1;
        rcnt_b = rcnt_b + 1;
      end else if (!sck_b && sck_p_b) begin
        miso_b = (rcnt_b >= 7 && rcnt_b <= 18) ? adc_b[18 - rcnt_b] : 1'b0;
      end
    end
    cs_p_b  = cs_n_b;
    sck_p_b = sck_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (pos < t) begin
      @(negedge clk);
      pos++;
    end
  endtask

  logic [2:0]  exp_ch_b  [4] = '{3'd0, 3'd4, 3'd7, 3'd0};
  logic [5:0]  exp_cmd_b [4] = '{6'h30, 6'h38, 6'h3E, 6'h30};
  logic [11:0] adc_tab_b [4] = '{12'hC3A, 12'h0F1, 12'h8E2, 12'h5D4};
  int          cs_snap;

  initial begin
    reset_n     = 1'b0;
    en_a        = 1'b0;
    o_ready_a   = 1'b0;
    ch_mask_a   = 2'b01;
    diff_mask_a = 2'b00;
    en_b        = 1'b0;
    o_ready_b   = 1'b1;
    ch_mask_b   = 8'h91;
    diff_mask_b = 8'h00;
    adc_a       = 12'hA5C;
    repeat (3) @(negedge clk);
    check("rst_cs_n",    32'(cs_n_a),    32'd1);
    check("rst_sck",     32'(sck_a),     32'd0);
    check("rst_mosi",    32'(mosi_a),    32'd0);
    check("rst_o_valid", 32'(o_valid_a), 32'd0);
    check("rst_o_data",  32'(o_data_a),  32'd0);
    check("rst_overrun", 32'(overrun_a), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Slot 0: single channel, full frame timing
    en_a = 1'b1;
    pos  = 0;
    wait_to(67);   check("s0_cs_setup",   32'(cs_n_a), 32'd1);
    wait_to(68);   check("s0_cs_fall",    32'(cs_n_a), 32'd0);
                   check("s0_mosi_start", 32'(mosi_a), 32'd1);
                   check("s0_sck_setup",  32'(sck_a),  32'd0);
    wait_to(142);  check("s0_sck_pre",    32'(sck_a),  32'd0);
    wait_to(143);  check("s0_sck_rise0",  32'(sck_a),  32'd1);
    wait_to(218);  check("s0_sck_fall0",  32'(sck_a),  32'd0);
                   check("s0_mosi_sgl",   32'(mosi_a), 32'd1);
    wait_to(2617); check("s0_cs_last",    32'(cs_n_a), 32'd0);
                   check("s0_valid_pre",  32'(o_valid_a), 32'd0);
    wait_to(2618); check("s0_cs_rise",    32'(cs_n_a), 32'd1);
                   check("s0_sck_end",    32'(sck_a),  32'd0);
                   check("s0_valid_end",  32'(o_valid_a), 32'd0);
    wait_to(2619); check("s0_valid",      32'(o_valid_a),   32'd1);
                   check("s0_data",       32'(o_data_a),    32'hA5C);
                   check("s0_channel",    32'(o_channel_a), 32'd0);
                   check("s0_overrun",    32'(overrun_a),   32'd0);
                   check("s0_cmd",        32'(cmd_cap_a),   32'hD);
                   check("s0_clocks",     32'(last_rcnt_a), 32'd17);

    // Slot 1: unconsumed result overwritten
    wait_to(SP_A); adc_a = 12'h3C7;
    wait_to(SP_A + 2618); check("s1_overrun_pre", 32'(overrun_a), 32'd0);
    wait_to(SP_A + 2619); check("s1_overrun",     32'(overrun_a), 32'd1);
                          check("s1_data",        32'(o_data_a),  32'h3C7);
                          check("s1_valid",       32'(o_valid_a), 32'd1);
    wait_to(SP_A + 2620); check("s1_overrun_end", 32'(overrun_a), 32'd0);

    // Slot 2: load coincident with accept
    wait_to(2 * SP_A); adc_a = 12'h5A3;
    wait_to(2 * SP_A + 2618); o_ready_a = 1'b1;
    wait_to(2 * SP_A + 2619); check("s2_valid",   32'(o_valid_a), 32'd1);
                              check("s2_overrun", 32'(overrun_a), 32'd0);
                              check("s2_data",    32'(o_data_a),  32'h5A3);
    wait_to(2 * SP_A + 2620); check("s2_consumed", 32'(o_valid_a), 32'd0);

    // Slot 3: enable dropped during clock 8
    wait_to(3 * SP_A + 1300); en_a = 1'b0;
    wait_to(3 * SP_A + 1301); check("abort_cs_n", 32'(cs_n_a), 32'd1);
                              check("abort_sck",  32'(sck_a),  32'd0);
                              check("abort_mosi", 32'(mosi_a), 32'd0);
    wait_to(3 * SP_A + 1400); check("abort_no_valid", 32'(o_valid_a), 32'd0);

    // Two channels, ch1 differential, scan restarts at ch0
    ch_mask_a   = 2'b11;
    diff_mask_a = 2'b10;
    en_a        = 1'b1;
    pos         = 0;
    for (int s = 0; s < 4; s++) begin
      wait_to(s * SP_A);
      adc_a = 12'(12'h111 * (s + 1));
      if (s == 0) begin
        wait_to(67); check("re_cs_setup", 32'(cs_n_a), 32'd1);
        wait_to(68); check("re_cs_fall",  32'(cs_n_a), 32'd0);
      end
      wait_to(s * SP_A + 2619);
      check("dual_valid",   32'(o_valid_a),   32'd1);
      check("dual_channel", 32'(o_channel_a), 32'(s % 2));
      check("dual_data",    32'(o_data_a),    32'(12'h111 * (s + 1)));
      check("dual_cmd",     32'(cmd_cap_a),   (s % 2 == 1) ? 32'hB : 32'hD);
    end

    // Asynchronous reset in the middle of clock 1 of a frame
    wait_to(4 * SP_A + 300);
    check("pre_rst_sck",  32'(sck_a),  32'd1);
    check("pre_rst_mosi", 32'(mosi_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_cs_n",    32'(cs_n_a),      32'd1);
    check("arst_sck",     32'(sck_a),       32'd0);
    check("arst_mosi",    32'(mosi_a),      32'd0);
    check("arst_o_data",  32'(o_data_a),    32'd0);
    check("arst_channel", 32'(o_channel_a), 32'd0);
    check("arst_o_valid", 32'(o_valid_a),   32'd0);
    check("arst_overrun", 32'(overrun_a),   32'd0);

    // Empty mask: no frames at all
    ch_mask_a = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    cs_snap = cs_low_a;
    repeat (SP_A + 200) @(negedge clk);
    check("idle_no_cs",    32'(cs_low_a - cs_snap), 32'd0);
    check("idle_no_valid", 32'(o_valid_a),          32'd0);
    en_a = 1'b0;

    // 8-channel format, sparse mask 0x91
    adc_b = adc_tab_b[0];
    en_b  = 1'b1;
    pos   = 0;
    wait_to(5); check("b_cs_setup", 32'(cs_n_b), 32'd1);
    wait_to(6); check("b_cs_fall",  32'(cs_n_b), 32'd0);
    for (int s = 0; s < 4; s++) begin
      wait_to(s * SP_B);
      adc_b = adc_tab_b[s];
      wait_to(s * SP_B + 81); check("b_cs_last", 32'(cs_n_b), 32'd0);
      wait_to(s * SP_B + 82); check("b_cs_rise", 32'(cs_n_b), 32'd1);
      wait_to(s * SP_B + 83);
      check("b_valid",   32'(o_valid_b),   32'd1);
      check("b_channel", 32'(o_channel_b), 32'(exp_ch_b[s]));
      check("b_data",    32'(o_data_b),    32'(adc_tab_b[s]));
      check("b_cmd",     32'(cmd_cap_b),   32'(exp_cmd_b[s]));
      check("b_clocks",  32'(last_rcnt_b), 32'd19);
    end
    en_b = 1'b0;

    check("a_mosi_tail", 32'(tail_bad_a), 32'd0);
    check("b_mosi_tail", 32'(tail_bad_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
